// File: rtl/input_stream_fetcher_pkg.sv
// input_fetch_pkg: shared FSM states and SRAM controller constants for the stream fetchers.
package input_fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} fetch_state_e;
  localparam int RD_LATENCY = 1;
  localparam int BANK_WORDS = 2048;
endpackage

// File: rtl/input_stream_fetcher_if.sv
// input_stream_fetcher_if: SRAM read port and PE-array output stream of the input fetcher.
interface input_stream_fetcher_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64) ();
  logic [ADDR_W-1:0] sram_r_addr;
  logic sram_r_en;
  logic [DATA_W-1:0] sram_r_d;
  logic sram_d_ready;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output sram_r_addr, sram_r_en, out_data, out_valid, input sram_r_d, sram_d_ready, out_ready);
  modport slave (input sram_r_addr, sram_r_en, out_data, out_valid, output sram_r_d, sram_d_ready, out_ready);
endinterface

// File: rtl/input_stream_fetcher_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count, no bypass.
module sync_fifo #(parameter int DATA_W = 64, parameter int DEPTH = 4) (
  input logic clock,
  input logic reset,
  input logic push,
  input logic pop,
  input logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clock) if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/input_stream_fetcher.sv
// input_stream_fetcher: credit-throttled sequential SRAM reader feeding a valid/ready stream.
module input_stream_fetcher import input_fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic clock,
  input logic reset,
  input logic start,
  input logic [ADDR_W-1:0] base_addr,
  input logic [LEN_W-1:0] num_words,
  output logic busy,
  output logic done,
  input_stream_fetcher_if.master sif
);
  localparam int CW = $clog2(FIFO_DEPTH);
  fetch_state_e state, next_state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0] len_q, issued;
  logic [CW:0] in_flight, fifo_count;
  logic fifo_full, fifo_empty, accept, issue, ret, pop;
  assign ret = sif.sram_d_ready && in_flight != '0;
  assign pop = sif.out_valid && sif.out_ready;
  assign busy = state != IDLE || done;
  assign sif.out_valid = !fifo_empty;
  always_ff @(posedge clock) state <= reset ? IDLE : next_state;
  // done is registered, so the IDLE cycle carrying it still counts as busy
  always_comb begin
    accept = 1'b0;
    issue = 1'b0;
    next_state = state;
    accept = state == IDLE && !done && start;
    issue = state == FETCH && issued != len_q && !fifo_full &&
            ({1'b0, fifo_count} + {1'b0, in_flight}) < (CW+2)'(FIFO_DEPTH);
    next_state = state == IDLE ? (accept ? (num_words == '0 ? FINISH : FETCH) : IDLE) :
                 state == FETCH ? (issued == len_q ? DRAIN : FETCH) :
                 state == DRAIN ? ((in_flight == '0 && fifo_empty) ? FINISH : DRAIN) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
      len_q <= '0;
      issued <= '0;
      in_flight <= '0;
      done <= 1'b0;
      sif.sram_r_en <= 1'b0;
      sif.sram_r_addr <= '0;
    end else begin
      done <= state == FINISH;
      sif.sram_r_en <= issue;
      if (issue) sif.sram_r_addr <= base_q + ADDR_W'(issued);
      if (accept) begin
        base_q <= base_addr;
        len_q <= num_words;
        issued <= '0;
      end else if (issue) issued <= issued + 1'b1;
      in_flight <= in_flight + (CW+1)'(issue) - (CW+1)'(ret);
    end
  end
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(ret),
    .pop(pop),
    .wdata(sif.sram_r_d),
    .rdata(sif.out_data),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_input_stream_fetcher.sv
// tb_input_stream_fetcher: scoreboard bench with SRAM controller model and random backpressure.
module tb_input_stream_fetcher;
  localparam int DEPTH = 4;
  logic clock = 0, reset = 1, start = 0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic busy, done;
  logic hold = 0, rnd = 0;
  int total = 0, bad = 0, rd_cnt = 0, outstanding = 0;
  longint cyc_g = 0, rd_first = 0, rd_last = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [31:0] ea;
  logic [63:0] ed;
  input_stream_fetcher_if #(.ADDR_W(32), .DATA_W(64)) sif ();
  input_stream_fetcher #(.ADDR_W(32), .DATA_W(64), .LEN_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .sif(sif)
  );
  always #5 clock = ~clock;
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // controller: latch request at the edge, return data for exactly the next cycle
  always @(posedge clock) begin
    sif.sram_d_ready <= sif.sram_r_en;
    sif.sram_r_d <= mem_word(sif.sram_r_addr);
  end
  initial forever begin
    @(posedge clock);
    #1 sif.out_ready = hold ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  end
  always @(negedge clock) begin
    cyc_g++;
    if (!reset && sif.sram_r_en === 1'b1) begin
      if (exp_addr.size() == 0) chk("unexpected_read", sif.sram_r_addr, 32'hx);
      else begin
        ea = exp_addr.pop_front();
        chk("rd_addr", sif.sram_r_addr, ea);
      end
      if (rd_cnt == 0) rd_first = cyc_g;
      rd_last = cyc_g;
      rd_cnt++;
      outstanding++;
      chk("credit_overflow", outstanding > DEPTH, 0);
    end
    if (!reset && sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
      if (exp_data.size() == 0) chk("unexpected_word", sif.out_data, 64'hx);
      else begin
        ed = exp_data.pop_front();
        chk("out_data", sif.out_data, ed);
      end
      outstanding--;
    end
  end
  task automatic xfer(input logic [31:0] base, input int n, input int lat_exp, input int stall);
    int first_v, done_cyc;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(i));
      exp_data.push_back(mem_word(base + 32'(i)));
    end
    rd_cnt = 0;
    first_v = -1;
    done_cyc = -1;
    @(posedge clock);
    #1 start = 1; base_addr = base; num_words = 16'(n);
    @(posedge clock);
    #1 start = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clock);
      if (stall > 0 && c == stall) begin
        chk("stall_reads", rd_cnt, DEPTH);
        hold = 0;
      end
      if (first_v < 0 && sif.out_valid) first_v = c;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    chk("done_seen", done_cyc > 0, 1);
    if (done_cyc > 0) begin
      chk("busy_at_done", busy, 1);
      @(negedge clock);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
    chk("addr_left", exp_addr.size(), 0);
    chk("data_left", exp_data.size(), 0);
    if (n == 0) begin
      chk("zero_done_cycle", done_cyc, 2);
      chk("zero_reads", rd_cnt, 0);
      chk("zero_no_valid", first_v, -1);
    end else if (lat_exp >= 0) begin
      chk("first_valid", first_v, lat_exp);
      chk("rd_consecutive", rd_last - rd_first, n - 1);
    end
  endtask
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r_en", sif.sram_r_en, 0);
    chk("rst_r_addr", sif.sram_r_addr, 0);
    chk("rst_valid", sif.out_valid, 0);
    @(posedge clock);
    #1 reset = 0;
    xfer(32'h10, 8, 4, 0);
    xfer(32'h7FE, 4, 4, 0);
    hold = 1;
    xfer(32'h40, 20, -1, 30);
    xfer(32'h55, 0, -1, 0);
    fork
      xfer(32'h200, 10, 4, 0);
      begin
        repeat (5) @(posedge clock);
        #1 start = 1; base_addr = 32'h9000; num_words = 16'd3;
        @(posedge clock);
        #1 start = 0;
      end
    join
    for (int i = 0; i < 10; i++) begin
      exp_addr.push_back(32'h300 + 32'(i));
      exp_data.push_back(mem_word(32'h300 + 32'(i)));
    end
    @(posedge clock);
    #1 start = 1; base_addr = 32'h300; num_words = 16'd10;
    @(posedge clock);
    #1 start = 0;
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_r_en", sif.sram_r_en, 1);
    #1 reset = 1;
    @(posedge clock);
    #1 reset = 0;
    exp_addr.delete();
    exp_data.delete();
    outstanding = 0;
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_r_en", sif.sram_r_en, 0);
    chk("abort_r_addr", sif.sram_r_addr, 0);
    chk("abort_valid", sif.out_valid, 0);
    @(negedge clock);
    chk("stray_ignored", sif.out_valid, 0);
    xfer(32'h1234, 6, 4, 0);
    rnd = 1;
    for (int k = 0; k < 10; k++) begin
      xfer((k == 3) ? 32'hFFFF_FFFD : $urandom, int'($urandom_range(0, 24)), -1, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
